flit_packetizer: RTL and testbench
==================================

// Module: flit_packetizer
// PURPOSE
//  Transmit-side packet builder for a router input port; sits in the local NI ahead of the router.
//  Takes a packet descriptor (dest X/Y, VC, length, head payload) plus a stream of 32-bit body words.
//  Emits a head flit followed by body flits and one tail flit on a valid/ready flit bus whose layout
//  matches the router's flit_req bundle {flit[33:0], vc_id[1:0], valid}.
//  The head carries the coordinates the router's XY/YX routing decodes; the tail closes the per-VC route.
// PARAMETERS
//  FLIT_W    34  flit width; [33:32] type, head: [31] X, [30] Y, [29:22] pkt size, [21:0] data
//  VC_W      2   VC id width (3 VCs used, id 3 illegal)
//  X_W / Y_W 1   destination coordinate widths (2x2 mesh)
//  PKT_W     8   pkt size field width; counts flits AFTER the head
// PORTS
//  clk           in   1    clock
//  arst_n        in   1    asynchronous active-low reset
//  pkt_valid_i   in   1    descriptor valid
//  pkt_ready_o   out  1    descriptor accepted when valid&ready
//  pkt_x_i       in   X_W  destination X
//  pkt_y_i       in   Y_W  destination Y
//  pkt_vc_i      in   VC_W VC for every flit of the packet
//  pkt_len_i     in   PKT_W number of flits after head (0 = head-only packet)
//  pkt_hdata_i   in   22   head flit payload
//  data_valid_i  in   1    body word valid
//  data_ready_o  out  1    body word accepted when valid&ready
//  data_i        in   32   body/tail payload
//  flit_req_o    out  FLIT_W+VC_W+1  {flit, vc_id, valid}; valid is bit 0
//  flit_ready_i  in   1    downstream accepts flit when flit_req_o[0] & flit_ready_i
// BEHAVIOUR
//  - Reset: flit_req_o = 0 (valid low), state IDLE, remaining count 0, latched VC 0; ready outputs low.
//  - Output register: one flit slot, out_v. Slot may load when !out_v | flit_ready_i (the "free" term).
//    While valid & !flit_ready_i, flit_req_o holds every bit stable.
//  - FSM IDLE: pkt_ready_o = free. On pkt handshake: load head
//    {2'b00, x, y, len, hdata} with vc = pkt_vc_i, valid = 1.
//    Latch vc and remaining = len. Go to BODY if len != 0, else stay IDLE.
//  - FSM BODY: pkt_ready_o = 0; data_ready_o = free (0 in IDLE).
//    On data handshake: load {type, data_i} with latched vc, then remaining -= 1.
//    type = 2'b10 (tail) when remaining == 1, else 2'b01 (body).
//    Return to IDLE after the tail is loaded.
//  - Latency: descriptor/word handshake in cycle N -> flit valid in cycle N+1.
//  - Throughput: 1 flit/cycle. The first body word may load in the same cycle the head is consumed.
//    Next descriptor may load in the same cycle the tail is consumed.
//  - Exactly len+1 flits per packet. len = 255 gives 255 body/tail flits, tail on the 255th word.
//  - pkt_vc_i = 3 is illegal; undefined and not checked.
//  - data_valid_i in IDLE is ignored (no ready). pkt_valid_i in BODY is held off.
//  - Reset mid-packet: asynchronous abort; flit valid drops immediately; partial packet discarded, no tail sent.
// CONFIGURATION
//  PKTZ_STATS_EN defined:
//  - adds pkt_sent_cnt_o [15:0] (+1 per tail, or per head when len = 0, at downstream handshake)
//    and flit_sent_cnt_o [15:0] (+1 per flit handshake).
//  - Both counters reset to 0 and wrap 16'hFFFF -> 0.
//  PKTZ_STATS_EN undefined: those ports and counters do not exist; all other behaviour identical.
// TESTING
//  - Reset: arst_n low mid-stream -> flit_req_o == 0 same cycle; pkt_ready_o == 0 until release, then 1 in IDLE.
//  - Head-only: x=1,y=0,vc=2,len=0,hdata=22'h15A5A, ready=1 -> one flit {2'b00,1,0,8'h00,22'h15A5A}, vc 2, next cycle; pkt_ready_o stays 1.
//  - 3-flit packet, vc=1, len=2, words 32'hDEADBEEF, 32'h01234567 -> head, body(01,DEADBEEF), tail(10,01234567) on 3 consecutive cycles.
//  - Backpressure: flit_ready_i low 4 cycles on body flit -> flit_req_o frozen, data_ready_o low, no word lost; resumes on ready.
//  - Back-to-back: two len=1 packets with ready always high -> 4 flits in 4 cycles, no bubble, VC switches at head.
//  - Max length len=255 -> tail type on 255th word only; with PKTZ_STATS_EN, pkt_sent_cnt_o=1 and flit_sent_cnt_o=256.

Source files
------------

// File: rtl/flit_packetizer.sv
// flit_packetizer: builds head/body/tail flits from a packet descriptor and a
// stream of 32-bit body words, and drives them onto a one-slot valid/ready
// flit bus {flit, vc_id, valid}.
// Optional build macro: PKTZ_STATS_EN adds packet and flit sent counters.
//
// Handshake rule on every port: a transfer happens in a cycle where both
// valid and ready are high at the clock edge. A source never withdraws or
// changes a valid item before it is taken. flit_req_o holds every bit stable
// while its valid bit is high and flit_ready_i is low.
module flit_packetizer #(
    parameter int FLIT_W = 34,
    parameter int VC_W   = 2,
    parameter int X_W    = 1,
    parameter int Y_W    = 1,
    parameter int PKT_W  = 8
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     pkt_valid_i,
    output logic                     pkt_ready_o,
    input  logic [X_W-1:0]           pkt_x_i,
    input  logic [Y_W-1:0]           pkt_y_i,
    input  logic [VC_W-1:0]          pkt_vc_i,
    input  logic [PKT_W-1:0]         pkt_len_i,
    input  logic [21:0]              pkt_hdata_i,
    input  logic                     data_valid_i,
    output logic                     data_ready_o,
    input  logic [31:0]              data_i,
    output logic [FLIT_W+VC_W:0]     flit_req_o,
    input  logic                     flit_ready_i,
`ifdef PKTZ_STATS_EN
    output logic [15:0]              pkt_sent_cnt_o,
    output logic [15:0]              flit_sent_cnt_o,
`endif
    output logic                     dbg_state_o
);

    // Bit position of the head's packet-size field MSB.
    localparam int SZ_MSB = FLIT_W - 3 - X_W - Y_W;
    localparam logic [PKT_W-1:0] ONE = 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic                en_q;
    logic                out_v_q, out_v_d;
    logic [FLIT_W-1:0]   out_flit_q, out_flit_d;
    logic [VC_W-1:0]     out_vc_q, out_vc_d;
    logic [VC_W-1:0]     vc_q, vc_d;
    logic [PKT_W-1:0]    rem_q, rem_d;
    logic                free;

    // State, output slot and per-packet context registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= ST_IDLE;
            en_q       <= 1'b0;
            out_v_q    <= 1'b0;
            out_flit_q <= '0;
            out_vc_q   <= '0;
            vc_q       <= '0;
            rem_q      <= '0;
        end else begin
            state_q    <= state_d;
            en_q       <= 1'b1;
            out_v_q    <= out_v_d;
            out_flit_q <= out_flit_d;
            out_vc_q   <= out_vc_d;
            vc_q       <= vc_d;
            rem_q      <= rem_d;
        end
    end

    // Next-state, slot loading and ready generation.
    always_comb begin
        state_d      = state_q;
        out_v_d      = out_v_q;
        out_flit_d   = out_flit_q;
        out_vc_d     = out_vc_q;
        vc_d         = vc_q;
        rem_d        = rem_q;
        pkt_ready_o  = 1'b0;
        data_ready_o = 1'b0;
        // The slot can take a new flit when empty or being drained this cycle.
        free         = !out_v_q || flit_ready_i;

        if (flit_ready_i) begin
            out_v_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // en_q keeps ready low until the first clock after reset release.
                pkt_ready_o = en_q && free;
                if (pkt_valid_i && pkt_ready_o) begin
                    out_flit_d = {2'b00, pkt_x_i, pkt_y_i, pkt_len_i, pkt_hdata_i};
                    out_vc_d   = pkt_vc_i;
                    out_v_d    = 1'b1;
                    vc_d       = pkt_vc_i;
                    rem_d      = pkt_len_i;
                    if (pkt_len_i != '0) begin
                        state_d = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                data_ready_o = free;
                if (data_valid_i && free) begin
                    out_flit_d = {((rem_q == ONE) ? 2'b10 : 2'b01), data_i};
                    out_vc_d   = vc_q;
                    out_v_d    = 1'b1;
                    rem_d      = rem_q - ONE;
                    if (rem_q == ONE) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign flit_req_o  = {out_flit_q, out_vc_q, out_v_q};
    assign dbg_state_o = state_q;

`ifdef PKTZ_STATS_EN
    logic [15:0] pkt_cnt_q;
    logic [15:0] flit_cnt_q;
    logic        flit_hs;
    logic        pkt_done;

    assign flit_hs  = out_v_q && flit_ready_i;
    // A packet completes on its tail, or on its head when it has no body.
    assign pkt_done = flit_hs &&
                      ((out_flit_q[FLIT_W-1 -: 2] == 2'b10) ||
                       ((out_flit_q[FLIT_W-1 -: 2] == 2'b00) &&
                        (out_flit_q[SZ_MSB -: PKT_W] == '0)));

    // Sent counters, free-running with natural 16-bit wrap.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pkt_cnt_q  <= '0;
            flit_cnt_q <= '0;
        end else begin
            if (pkt_done) pkt_cnt_q  <= pkt_cnt_q + 16'd1;
            if (flit_hs)  flit_cnt_q <= flit_cnt_q + 16'd1;
        end
    end

    assign pkt_sent_cnt_o  = pkt_cnt_q;
    assign flit_sent_cnt_o = flit_cnt_q;
`endif

endmodule

// File: tb/tb_flit_packetizer.sv
// tb_flit_packetizer: directed bench for flit_packetizer. Inputs change and
// outputs are sampled on the falling clock edge; combinational readies are
// sampled 1 ns after the inputs change.
module tb_flit_packetizer;

    logic        clk;
    logic        arst_n;
    logic        pkt_valid_i;
    logic        pkt_ready_o;
    logic [0:0]  pkt_x_i;
    logic [0:0]  pkt_y_i;
    logic [1:0]  pkt_vc_i;
    logic [7:0]  pkt_len_i;
    logic [21:0] pkt_hdata_i;
    logic        data_valid_i;
    logic        data_ready_o;
    logic [31:0] data_i;
    logic [36:0] flit_req_o;
    logic        flit_ready_i;
    logic        dbg_state_o;
`ifdef PKTZ_STATS_EN
    logic [15:0] pkt_sent_cnt_o;
    logic [15:0] flit_sent_cnt_o;
`endif

    int n_pass;
    int n_total;

    flit_packetizer dut (
        .clk             (clk),
        .arst_n          (arst_n),
        .pkt_valid_i     (pkt_valid_i),
        .pkt_ready_o     (pkt_ready_o),
        .pkt_x_i         (pkt_x_i),
        .pkt_y_i         (pkt_y_i),
        .pkt_vc_i        (pkt_vc_i),
        .pkt_len_i       (pkt_len_i),
        .pkt_hdata_i     (pkt_hdata_i),
        .data_valid_i    (data_valid_i),
        .data_ready_o    (data_ready_o),
        .data_i          (data_i),
        .flit_req_o      (flit_req_o),
        .flit_ready_i    (flit_ready_i),
`ifdef PKTZ_STATS_EN
        .pkt_sent_cnt_o  (pkt_sent_cnt_o),
        .flit_sent_cnt_o (flit_sent_cnt_o),
`endif
        .dbg_state_o     (dbg_state_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, assert equality, report on failure.
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Expected flit bus word for a valid flit.
    function automatic logic [36:0] mk(input logic [1:0] typ, input logic [31:0] body,
                                       input logic [1:0] vc);
        return {typ, body, vc, 1'b1};
    endfunction

    function automatic logic [36:0] mk_head(input logic x, input logic y, input logic [7:0] len,
                                            input logic [21:0] hd, input logic [1:0] vc);
        return {2'b00, x, y, len, hd, vc, 1'b1};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_pkt(input logic v, input logic x, input logic y, input logic [1:0] vc,
                           input logic [7:0] len, input logic [21:0] hd);
        pkt_valid_i = v;
        pkt_x_i     = x;
        pkt_y_i     = y;
        pkt_vc_i    = vc;
        pkt_len_i   = len;
        pkt_hdata_i = hd;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        arst_n       = 1'b0;
        set_pkt(1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 22'd0);
        data_valid_i = 1'b0;
        data_i       = 32'd0;
        flit_ready_i = 1'b1;

        // ---- Reset state ----
        step();
        chk("rst_flit", 64'(flit_req_o), 64'd0);
        chk("rst_pkt_ready", 64'(pkt_ready_o), 64'd0);
        chk("rst_data_ready", 64'(data_ready_o), 64'd0);
        arst_n = 1'b1;
        step();
        step();
        chk("post_rst_pkt_ready", 64'(pkt_ready_o), 64'd1);
        chk("post_rst_state", 64'(dbg_state_o), 64'd0);

        // ---- Head-only packet ----
        set_pkt(1'b1, 1'b1, 1'b0, 2'd2, 8'd0, 22'h15A5A);
        #1;
        chk("ho_pkt_ready", 64'(pkt_ready_o), 64'd1);
        step();
        chk("ho_flit", 64'(flit_req_o), 64'(mk_head(1'b1, 1'b0, 8'h00, 22'h15A5A, 2'd2)));
        chk("ho_state", 64'(dbg_state_o), 64'd0);
        pkt_valid_i = 1'b0;
        #1;
        chk("ho_pkt_ready_hold", 64'(pkt_ready_o), 64'd1);
        step();
        chk("ho_drained", 64'(flit_req_o[0]), 64'd0);

        // ---- 3-flit packet, words ignored while idle ----
        set_pkt(1'b1, 1'b0, 1'b1, 2'd1, 8'd2, 22'h2AAAA);
        data_valid_i = 1'b1;
        data_i       = 32'hDEADBEEF;
        #1;
        chk("p3_idle_data_ready", 64'(data_ready_o), 64'd0);
        step();
        chk("p3_head", 64'(flit_req_o), 64'(mk_head(1'b0, 1'b1, 8'd2, 22'h2AAAA, 2'd1)));
        chk("p3_state_body", 64'(dbg_state_o), 64'd1);
        pkt_valid_i = 1'b0;
        #1;
        chk("p3_body_pkt_ready", 64'(pkt_ready_o), 64'd0);
        chk("p3_data_ready", 64'(data_ready_o), 64'd1);
        step();
        chk("p3_body", 64'(flit_req_o), 64'(mk(2'b01, 32'hDEADBEEF, 2'd1)));
        data_i = 32'h01234567;
        step();
        chk("p3_tail", 64'(flit_req_o), 64'(mk(2'b10, 32'h01234567, 2'd1)));
        chk("p3_state_idle", 64'(dbg_state_o), 64'd0);
        data_valid_i = 1'b0;
        step();
        chk("p3_drained", 64'(flit_req_o[0]), 64'd0);

        // ---- Backpressure on a body flit ----
        set_pkt(1'b1, 1'b1, 1'b1, 2'd0, 8'd3, 22'h00001);
        step();
        chk("bp_head", 64'(flit_req_o), 64'(mk_head(1'b1, 1'b1, 8'd3, 22'h00001, 2'd0)));
        pkt_valid_i  = 1'b0;
        data_valid_i = 1'b1;
        data_i       = 32'hA0000001;
        step();
        chk("bp_body1", 64'(flit_req_o), 64'(mk(2'b01, 32'hA0000001, 2'd0)));
        flit_ready_i = 1'b0;
        data_i       = 32'hA0000002;
        #1;
        chk("bp_data_ready_low", 64'(data_ready_o), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("bp_frozen_%0d", i), 64'(flit_req_o), 64'(mk(2'b01, 32'hA0000001, 2'd0)));
            chk($sformatf("bp_stall_ready_%0d", i), 64'(data_ready_o), 64'd0);
        end
        flit_ready_i = 1'b1;
        #1;
        chk("bp_resume_ready", 64'(data_ready_o), 64'd1);
        step();
        chk("bp_body2", 64'(flit_req_o), 64'(mk(2'b01, 32'hA0000002, 2'd0)));
        data_i = 32'hA0000003;
        step();
        chk("bp_tail", 64'(flit_req_o), 64'(mk(2'b10, 32'hA0000003, 2'd0)));
        data_valid_i = 1'b0;
        step();
        chk("bp_drained", 64'(flit_req_o[0]), 64'd0);

        // ---- Back-to-back len=1 packets ----
        set_pkt(1'b1, 1'b1, 1'b1, 2'd1, 8'd1, 22'h00011);
        step();
        chk("b2b_head_a", 64'(flit_req_o), 64'(mk_head(1'b1, 1'b1, 8'd1, 22'h00011, 2'd1)));
        set_pkt(1'b1, 1'b0, 1'b0, 2'd2, 8'd1, 22'h00022);
        data_valid_i = 1'b1;
        data_i       = 32'h0000AAAA;
        step();
        chk("b2b_tail_a", 64'(flit_req_o), 64'(mk(2'b10, 32'h0000AAAA, 2'd1)));
        data_i = 32'h0000BBBB;
        #1;
        chk("b2b_pkt_ready", 64'(pkt_ready_o), 64'd1);
        step();
        chk("b2b_head_b", 64'(flit_req_o), 64'(mk_head(1'b0, 1'b0, 8'd1, 22'h00022, 2'd2)));
        pkt_valid_i = 1'b0;
        step();
        chk("b2b_tail_b", 64'(flit_req_o), 64'(mk(2'b10, 32'h0000BBBB, 2'd2)));
        data_valid_i = 1'b0;
        step();
        chk("b2b_drained", 64'(flit_req_o[0]), 64'd0);

        // ---- Reset mid-packet ----
        set_pkt(1'b1, 1'b0, 1'b1, 2'd2, 8'd5, 22'h00033);
        step();
        pkt_valid_i  = 1'b0;
        data_valid_i = 1'b1;
        data_i       = 32'h55555555;
        step();
        chk("mr_body", 64'(flit_req_o), 64'(mk(2'b01, 32'h55555555, 2'd2)));
        arst_n       = 1'b0;
        data_valid_i = 1'b0;
        #1;
        chk("mr_flit_zero", 64'(flit_req_o), 64'd0);
        chk("mr_pkt_ready", 64'(pkt_ready_o), 64'd0);
        chk("mr_data_ready", 64'(data_ready_o), 64'd0);
        chk("mr_state", 64'(dbg_state_o), 64'd0);
        step();
        chk("mr_pkt_ready_hold", 64'(pkt_ready_o), 64'd0);
        arst_n = 1'b1;
        step();
        step();
        chk("mr_pkt_ready_rel", 64'(pkt_ready_o), 64'd1);
        chk("mr_flit_idle", 64'(flit_req_o), 64'd0);
`ifdef PKTZ_STATS_EN
        chk("mr_pkt_cnt", 64'(pkt_sent_cnt_o), 64'd0);
        chk("mr_flit_cnt", 64'(flit_sent_cnt_o), 64'd0);
`endif

        // ---- Maximum length packet ----
        set_pkt(1'b1, 1'b0, 1'b0, 2'd1, 8'd255, 22'h3FFFFF);
        step();
        chk("max_head", 64'(flit_req_o), 64'(mk_head(1'b0, 1'b0, 8'd255, 22'h3FFFFF, 2'd1)));
        pkt_valid_i  = 1'b0;
        data_valid_i = 1'b1;
        data_i       = 32'd1;
        for (int k = 1; k <= 255; k++) begin
            step();
            chk($sformatf("max_flit_%0d", k), 64'(flit_req_o),
                64'(mk((k == 255) ? 2'b10 : 2'b01, 32'(k), 2'd1)));
            data_i = 32'(k + 1);
        end
        data_valid_i = 1'b0;
        step();
        chk("max_drained", 64'(flit_req_o[0]), 64'd0);
        chk("max_state", 64'(dbg_state_o), 64'd0);
`ifdef PKTZ_STATS_EN
        chk("max_pkt_cnt", 64'(pkt_sent_cnt_o), 64'd1);
        chk("max_flit_cnt", 64'(flit_sent_cnt_o), 64'd256);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
